// File: rtl/obf_parity_chk.sv
`default_nettype none
// ============================================================================
//  Module      : obf_parity_chk
//  Description : Serial parity-frame receiver. Deserialises frames of DATA_W
//                data bits (LSB first) followed by one parity bit, checks the
//                parity and presents each word with an error flag on a
//                valid/ready output. Keeps saturating error/abort counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       clock, rising edge
//    rst        in   1       synchronous reset, active high
//    in_valid   in   1       in_bit/in_sof valid this cycle
//    in_sof     in   1       first data bit of a frame
//    in_bit     in   1       serial bit
//    in_ready   out  1       bit accepted when in_valid && in_ready
//    out_valid  out  1       out_data/out_perr valid
//    out_ready  in   1       consumer accepts word
//    out_data   out  DATA_W  received word, bit0 = first bit received
//    out_perr   out  1       parity mismatch for out_data
//    err_cnt    out  CNT_W   parity-error frames, saturating
//    abort_cnt  out  CNT_W   frames aborted by early in_sof, saturating
// ============================================================================
module obf_parity_chk #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  abort_cnt
);

  localparam int              BC_W     = $clog2(DATA_W);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic            ODD      = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              accept;
  logic              frame_perr;

  // Only the parity bit can be back-pressured: it is the one that produces a
  // new word, and it may only do so when the output register is free.
  assign in_ready   = !((state == PARITY) && out_valid && !out_ready);
  assign accept     = in_valid && in_ready;
  assign frame_perr = (^shreg) ^ in_bit ^ ODD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_perr  <= 1'b0;
      err_cnt   <= '0;
      abort_cnt <= '0;
    end else begin
      // Handshake clears the word; a load below in the same cycle overrides.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        case (state)
          IDLE: begin
            // Bits outside a frame are discarded until a start-of-frame.
            if (in_sof) begin
              shreg[0] <= in_bit;
              bit_cnt  <= BC_ONE;
              state    <= DATA;
            end
          end

          DATA: begin
            if (in_sof) begin
              if (abort_cnt != CNT_MAX) abort_cnt <= abort_cnt + CNT_ONE;
              shreg[0] <= in_bit;
              bit_cnt  <= BC_ONE;
            end else begin
              shreg[bit_cnt] <= in_bit;
              if (bit_cnt == BC_LAST) begin
                // Counter is parked at 0 while waiting for the parity bit.
                bit_cnt <= '0;
                state   <= PARITY;
              end else begin
                bit_cnt <= bit_cnt + BC_ONE;
              end
            end
          end

          PARITY: begin
            if (in_sof) begin
              if (abort_cnt != CNT_MAX) abort_cnt <= abort_cnt + CNT_ONE;
              shreg[0] <= in_bit;
              bit_cnt  <= BC_ONE;
              state    <= DATA;
            end else begin
              out_data  <= shreg;
              out_perr  <= frame_perr;
              out_valid <= 1'b1;
              if (frame_perr && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_ONE;
              bit_cnt   <= '0;
              state     <= IDLE;
            end
          end

          default: begin
            bit_cnt <= '0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/obf_parity_chk.md
Name: obf_parity_chk

Overview:
- Receive-side counterpart to the XOR-reduction parity generator.
- Accepts a serial bit stream of frames, each DATA_W data bits (LSB first) followed by one parity bit, and deserialises each frame.
- Checks each frame against the configured parity sense and presents the word with an error flag on a valid/ready output.
- Sits between a serial link/obfuscated datapath and word-level consumers; also keeps saturating error/abort statistics.

Parameters:
- DATA_W, 8, data bits per frame (>=2).
- PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data bits), 1 = odd parity (parity bit = ~XOR of data bits).
- CNT_W, 8, width of statistic counters.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_bit/in_sof valid this cycle.
- in_sof  input  1  marks first data bit of a frame.
- in_bit  input  1  serial bit.
- in_ready  output  1  bit accepted when in_valid && in_ready.
- out_valid  output  1  out_data/out_perr valid.
- out_ready  input  1  consumer accepts word.
- out_data  output  DATA_W  received word, bit0 = first bit received.
- out_perr  output  1  parity mismatch for out_data.
- err_cnt  output  CNT_W  parity-error frames, saturating.
- abort_cnt  output  CNT_W  frames aborted by early in_sof, saturating.

Behaviour:
- Reset: rst sampled high at a clk edge -> state IDLE, bit counter 0, shift reg 0, out_valid 0, out_data 0, out_perr 0, err_cnt 0, abort_cnt 0. rst mid-frame discards the partial frame and any held output word; no counter update.
- Accepted bit = in_valid && in_ready.
- State IDLE:
  - Accepted bit with in_sof=1 stores the bit at data position 0, bit counter = 1, -> DATA.
  - Accepted bit with in_sof=0 is dropped, stay IDLE.
- State DATA:
  - Accepted bit with in_sof=0 stores at position bit counter, counter++. When the stored bit was position DATA_W-1 -> PARITY.
  - Accepted bit with in_sof=1 aborts the current frame: abort_cnt++ (saturate at all-ones), bit stored at position 0, counter = 1, stay DATA.
- State PARITY:
  - Accepted bit with in_sof=0 is the parity bit p. Load out_data = shift reg, out_perr = (^data) ^ p ^ PARITY_ODD, out_valid = 1 on the next edge. If out_perr=1, err_cnt++ (saturating). -> IDLE.
  - Accepted bit with in_sof=1: abort as in DATA (abort_cnt++, new frame bit0, counter=1) -> DATA; no output.
- in_ready: 1 in all states except PARITY while out_valid=1 && out_ready=0. Deserialisation never stalls otherwise; only the final parity bit waits for output space.
- Output handshake:
  - Word is held stable while out_valid && !out_ready.
  - out_valid && out_ready clears out_valid, unless a new load occurs in the same cycle: load wins, out_valid stays 1 with the new word. This allows back-to-back frames with no bubble.
- Latency: parity bit accepted at edge N -> out_valid=1 visible after edge N (cycle N+1). Minimum frame period DATA_W+1 accepted bits.
- in_valid=0 cycles: state, counter and shift reg hold; gaps anywhere in a frame are legal.
- Counters saturate at 2^CNT_W-1 and never wrap. Both counters may increment in different cycles only; no simultaneous case exists.
- in_bit/in_sof are ignored when in_valid=0.

Test Plan (DATA_W=8, PARITY_ODD=0, CNT_W=8):
1. After rst, send sof+bits 1,0,1,0,0,1,0,1 then parity 0, out_ready=1 -> one cycle out_valid=1, out_data=0xA5, out_perr=0, err_cnt=0.
2. Same frame with parity 1 -> out_data=0xA5, out_perr=1, err_cnt=1. With PARITY_ODD=1 and parity 1 -> out_perr=0.
3. Hold out_ready=0, send two frames 0xA5/p0 then 0x3C/p0:
   - in_ready drops in PARITY of the second frame; 0xA5 held stable.
   - Raise out_ready -> 0xA5 taken; same cycle 0x3C loads, out_valid stays 1; next handshake yields 0x3C.
4. Send sof + 4 bits, then sof + full frame 0x0F/p0 -> abort_cnt=1, single output 0x0F, out_perr=0. Also bits without sof in IDLE -> no output, no counter change.
5. Assert rst after 5 data bits and with a word held (out_valid=1) -> next cycle out_valid=0, all counters 0; the following complete frame 0xA5/p0 decodes correctly.
6. Force 300 parity-error frames -> err_cnt stops at 255. Insert random in_valid=0 gaps in a frame -> same result as gap-free.
